// File: rtl/branch_resolve_bht.sv
// Branch resolution unit with a BHT of saturating counters.
// The IF side reads a counter to predict taken branches. The MEM side
// resolves branches and jumps, drives the redirect and flush, and trains
// the BHT. Statistics counters update one cycle after resolution.
module branch_resolve_bht #(
    parameter int XLEN       = 32,
    parameter int BHT_IDX_W  = 6,
    parameter int CTR_W      = 2,
    parameter int STAT_W     = 32,
    parameter int PREDICT_EN = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [XLEN-1:0]   i_pc_if,
    output logic              o_pred_taken_if,
    input  logic              i_valid_mem,
    input  logic [31:0]       i_inst_mem,
    input  logic [XLEN-1:0]   i_pc_mem,
    input  logic [XLEN-1:0]   i_target_mem,
    input  logic              i_br_less_mem,
    input  logic              i_br_equal_mem,
    input  logic              i_pred_taken_mem,
    output logic              o_pc_sel,
    output logic [XLEN-1:0]   o_redirect_pc,
    output logic              o_flush,
    output logic              o_illegal_br,
    output logic [STAT_W-1:0] o_br_count,
    output logic [STAT_W-1:0] o_mispred_count
);

    localparam int               ENTRIES   = 1 << BHT_IDX_W;
    localparam logic [CTR_W-1:0] CTR_MAX   = '1;
    // Weakly not-taken: all ones shifted right (0 when CTR_W == 1).
    localparam logic [CTR_W-1:0] CTR_RST   = CTR_MAX >> 1;
    localparam logic [6:0]       OP_BRANCH = 7'b1100011;
    localparam logic [6:0]       OP_JAL    = 7'b1101111;
    localparam logic [6:0]       OP_JALR   = 7'b1100111;

    // Saturating up/down step of one history counter.
    function automatic logic [CTR_W-1:0] ctr_train(input logic [CTR_W-1:0] c,
                                                   input logic taken);
        if (taken) begin
            return (c == CTR_MAX) ? c : c + CTR_W'(1);
        end
        return (c == '0) ? c : c - CTR_W'(1);
    endfunction

    logic [CTR_W-1:0]     ctr_q [ENTRIES];
    logic [CTR_W-1:0]     ctr_d;
    logic [STAT_W-1:0]    br_cnt_q, br_cnt_d;
    logic [STAT_W-1:0]    mis_cnt_q, mis_cnt_d;
    logic [BHT_IDX_W-1:0] idx_if, idx_mem;
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic                 is_branch, is_jump, illegal, legal;
    logic                 actual_taken, mispredict, train;
    logic [XLEN-1:0]      pc_plus4;

    // Bits that never take part in indexing or decode.
    logic unused_bits;
    assign unused_bits = ^{i_pc_if[XLEN-1:BHT_IDX_W+2], i_pc_if[1:0],
                           i_inst_mem[31:15], i_inst_mem[11:7]};

    assign idx_if   = i_pc_if[BHT_IDX_W+1:2];
    assign idx_mem  = i_pc_mem[BHT_IDX_W+1:2];
    assign opcode   = i_inst_mem[6:0];
    assign funct3   = i_inst_mem[14:12];
    assign pc_plus4 = i_pc_mem + XLEN'(4);

    // Prediction reads the registered counter, so a same-cycle update is not visible.
    generate
        if (PREDICT_EN != 0) begin : g_dyn_pred
            assign o_pred_taken_if = !i_reset && ctr_q[idx_if][CTR_W-1];
        end else begin : g_static_pred
            assign o_pred_taken_if = 1'b0;
        end
    endgenerate

    // MEM-stage decode, outcome and redirect selection.
    always_comb begin
        is_branch    = 1'b0;
        is_jump      = 1'b0;
        illegal      = 1'b0;
        legal        = 1'b0;
        actual_taken = 1'b0;
        mispredict   = 1'b0;
        train        = 1'b0;
        o_pc_sel     = 1'b0;
        o_illegal_br = 1'b0;

        is_branch = i_valid_mem && (opcode == OP_BRANCH);
        is_jump   = i_valid_mem && ((opcode == OP_JAL) || (opcode == OP_JALR));
        illegal   = is_branch && (funct3[2:1] == 2'b01);
        legal     = is_branch && !illegal;

        if (legal) begin
            case (funct3)
                3'b000:         actual_taken = i_br_equal_mem;
                3'b001:         actual_taken = !i_br_equal_mem;
                3'b100, 3'b110: actual_taken = i_br_less_mem;
                3'b101, 3'b111: actual_taken = !i_br_less_mem;
                default:        actual_taken = 1'b0;
            endcase
        end

        // An illegal branch resolves not-taken; if fetch went down the
        // predicted-taken path it still has to come back to pc+4.
        mispredict    = is_branch && (actual_taken != i_pred_taken_mem);
        o_pc_sel      = !i_reset && (is_jump || mispredict);
        o_illegal_br  = !i_reset && illegal;
        o_redirect_pc = (is_jump || actual_taken) ? i_target_mem : pc_plus4;
        train         = !i_reset && legal;
    end

    assign o_flush = o_pc_sel;

    // Next counter value and statistics increments.
    always_comb begin
        ctr_d     = ctr_train(ctr_q[idx_mem], actual_taken);
        br_cnt_d  = br_cnt_q + STAT_W'(1);
        mis_cnt_d = mis_cnt_q + (mispredict ? STAT_W'(1) : STAT_W'(0));
    end

    // BHT training; reset discards all history.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_RST;
            end
        end else if (train) begin
            ctr_q[idx_mem] <= ctr_d;
        end
    end

    // Statistics counters, wrapping naturally at STAT_W bits.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else if (train) begin
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign o_br_count      = br_cnt_q;
    assign o_mispred_count = mis_cnt_q;

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Self-checking bench for branch_resolve_bht: directed scenarios plus a
// randomized run against a behavioural model of the BHT and statistics.
module tb_branch_resolve_bht;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] pc_if, inst, pc_mem, target;
    logic        valid, lt, eq, pred;
    logic        pred_if, pred_if0, pc_sel, flush, ill;
    logic        pc_sel0, flush0, ill0;
    logic [31:0] redir, brc, misc, redir0, brc0, misc0;

    branch_resolve_bht #(.XLEN(32), .BHT_IDX_W(6), .CTR_W(2), .STAT_W(32), .PREDICT_EN(1)) dut (
        .i_clk(clk), .i_reset(reset), .i_pc_if(pc_if), .o_pred_taken_if(pred_if),
        .i_valid_mem(valid), .i_inst_mem(inst), .i_pc_mem(pc_mem), .i_target_mem(target),
        .i_br_less_mem(lt), .i_br_equal_mem(eq), .i_pred_taken_mem(pred),
        .o_pc_sel(pc_sel), .o_redirect_pc(redir), .o_flush(flush), .o_illegal_br(ill),
        .o_br_count(brc), .o_mispred_count(misc));

    branch_resolve_bht #(.XLEN(32), .BHT_IDX_W(6), .CTR_W(2), .STAT_W(32), .PREDICT_EN(0)) dut_static (
        .i_clk(clk), .i_reset(reset), .i_pc_if(pc_if), .o_pred_taken_if(pred_if0),
        .i_valid_mem(valid), .i_inst_mem(inst), .i_pc_mem(pc_mem), .i_target_mem(target),
        .i_br_less_mem(lt), .i_br_equal_mem(eq), .i_pred_taken_mem(pred),
        .o_pc_sel(pc_sel0), .o_redirect_pc(redir0), .o_flush(flush0), .o_illegal_br(ill0),
        .o_br_count(brc0), .o_mispred_count(misc0));

    int total = 0;
    int bad   = 0;

    // Behavioural model: one integer counter (0..3) per entry, plain statistics.
    int m_ctr [64];
    int m_br, m_mis;

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] op);
        return {17'd0, f3, 5'd0, op};
    endfunction

    function automatic bit act_of(input logic [2:0] f3, input logic e, input logic l);
        case (f3)
            3'd0:       return e;
            3'd1:       return !e;
            3'd4, 3'd6: return l;
            3'd5, 3'd7: return !l;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic bit is_legal_b();
        return valid && inst[6:0] == 7'h63 && inst[14:12] != 3'd2 && inst[14:12] != 3'd3;
    endfunction

    function automatic bit exp_pred(input logic [31:0] pc);
        return !reset && (m_ctr[(pc >> 2) % 64] >= 2);
    endfunction

    // Expected combinational MEM outputs for the current inputs.
    task automatic exp_mem(output bit sel, output logic [31:0] rpc, output bit il);
        bit a, isb, isj;
        isb = valid && inst[6:0] == 7'h63;
        isj = valid && (inst[6:0] == 7'h6F || inst[6:0] == 7'h67);
        il  = isb && (inst[14:12] == 3'd2 || inst[14:12] == 3'd3);
        a   = isb && !il && act_of(inst[14:12], eq, lt);
        sel = isj || (isb && a != pred);
        rpc = (isj || a) ? target : pc_mem + 32'd4;
        if (reset) begin
            sel = 1'b0;
            il  = 1'b0;
        end
    endtask

    // Model state change at a clock edge.
    task automatic model_edge();
        int idx;
        bit a;
        idx = int'((pc_mem >> 2) % 64);
        if (reset) begin
            foreach (m_ctr[i]) m_ctr[i] = 1;
            m_br  = 0;
            m_mis = 0;
        end else if (is_legal_b()) begin
            a = act_of(inst[14:12], eq, lt);
            m_ctr[idx] = a ? ((m_ctr[idx] + 1 > 3) ? 3 : m_ctr[idx] + 1)
                           : ((m_ctr[idx] - 1 < 0) ? 0 : m_ctr[idx] - 1);
            m_br++;
            if (a != pred) m_mis++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_mem(input logic v, input logic [31:0] in, input logic [31:0] pc,
                           input logic [31:0] tg, input logic l, input logic e, input logic p);
        valid = v; inst = in; pc_mem = pc; target = tg; lt = l; eq = e; pred = p;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        pc_if = 32'h40;
        set_mem(1, mk(3'd2, 7'h63), 32'h40, 32'h80, 0, 1, 1);
        #3;
        total++; if (pc_sel !== 1'b0) begin bad++; $display("FAIL rst_pc_sel got %b want 0", pc_sel); end
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL rst_flush got %b want 0", flush); end
        total++; if (ill !== 1'b0) begin bad++; $display("FAIL rst_illegal got %b want 0", ill); end
        total++; if (pred_if !== 1'b0) begin bad++; $display("FAIL rst_pred got %b want 0", pred_if); end
        tick();
        tick();
        reset = 1'b0;
        set_mem(0, 32'h13, 32'h0, 32'h0, 0, 0, 0);
        #3;
        total++; if (brc !== 32'd0) begin bad++; $display("FAIL rst_br_count got %0d want 0", brc); end
        total++; if (misc !== 32'd0) begin bad++; $display("FAIL rst_mis_count got %0d want 0", misc); end
        total++; if (pred_if !== 1'b0) begin bad++; $display("FAIL rst_weak_nt got %b want 0", pred_if); end
        tick();
    endtask

    task automatic test_beq_train();
        pc_if = 32'h40;
        set_mem(1, mk(3'd0, 7'h63), 32'h40, 32'h80, 0, 1, 0);
        #3;
        total++; if (pc_sel !== 1'b1) begin bad++; $display("FAIL beq_taken_sel got %b want 1", pc_sel); end
        total++; if (redir !== 32'h80) begin bad++; $display("FAIL beq_taken_redir got %h want 00000080", redir); end
        total++; if (pred_if !== 1'b0) begin bad++; $display("FAIL beq_same_cycle_pred got %b want 0", pred_if); end
        tick();
        set_mem(0, 32'h13, 32'h0, 32'h0, 0, 0, 0);
        #3;
        total++; if (brc !== 32'd1) begin bad++; $display("FAIL beq_br_count got %0d want 1", brc); end
        total++; if (misc !== 32'd1) begin bad++; $display("FAIL beq_mis_count got %0d want 1", misc); end
        total++; if (pred_if !== 1'b1) begin bad++; $display("FAIL beq_trained_pred got %b want 1", pred_if); end
        total++; if (pred_if0 !== 1'b0) begin bad++; $display("FAIL static_pred got %b want 0", pred_if0); end
        set_mem(1, mk(3'd0, 7'h63), 32'h40, 32'h80, 0, 0, 1);
        #1;
        total++; if (redir !== 32'h44) begin bad++; $display("FAIL beq_nt_redir got %h want 00000044", redir); end
        total++; if (flush !== 1'b1) begin bad++; $display("FAIL beq_nt_flush got %b want 1", flush); end
        tick();
        for (int i = 0; i < 4; i++) begin
            set_mem(1, mk(3'd0, 7'h63), 32'h40, 32'h80, 0, 1, exp_pred(32'h40));
            tick();
        end
        set_mem(0, 32'h13, 32'h0, 32'h0, 0, 0, 0);
        #3;
        total++; if (pred_if !== 1'b1) begin bad++; $display("FAIL sat_pred got %b want 1", pred_if); end
        total++; if (brc !== 32'(m_br)) begin bad++; $display("FAIL sat_br_count got %0d want %0d", brc, m_br); end
        total++; if (misc !== 32'(m_mis)) begin bad++; $display("FAIL sat_mis_count got %0d want %0d", misc, m_mis); end
        // Saturated at 3: one not-taken leaves it predicting taken, a second does not.
        set_mem(1, mk(3'd0, 7'h63), 32'h40, 32'h80, 0, 0, 1);
        tick();
        #3;
        total++; if (pred_if !== 1'b1) begin bad++; $display("FAIL sat_dec1_pred got %b want 1", pred_if); end
        tick();
        set_mem(0, 32'h13, 32'h0, 32'h0, 0, 0, 0);
        #3;
        total++; if (pred_if !== 1'b0) begin bad++; $display("FAIL sat_dec2_pred got %b want 0", pred_if); end
        tick();
    endtask

    task automatic test_bne();
        logic [31:0] b0, m0;
        b0 = brc; m0 = misc;
        set_mem(1, mk(3'd1, 7'h63), 32'h100, 32'h180, 0, 1, 0);
        #3;
        total++; if (pc_sel !== 1'b0) begin bad++; $display("FAIL bne_sel got %b want 0", pc_sel); end
        tick();
        total++; if (brc !== b0 + 32'd1) begin bad++; $display("FAIL bne_br_count got %0d want %0d", brc, b0 + 1); end
        total++; if (misc !== m0) begin bad++; $display("FAIL bne_mis_count got %0d want %0d", misc, m0); end
    endtask

    task automatic test_jump();
        logic [31:0] b0, m0;
        b0 = brc; m0 = misc;
        pc_if = 32'h200;
        set_mem(1, mk(3'd0, 7'h67), 32'h200, 32'h1234, 0, 0, 0);
        #3;
        total++; if (pc_sel !== 1'b1) begin bad++; $display("FAIL jalr_sel got %b want 1", pc_sel); end
        total++; if (redir !== 32'h1234) begin bad++; $display("FAIL jalr_redir got %h want 00001234", redir); end
        tick();
        total++; if (brc !== b0 || misc !== m0) begin bad++; $display("FAIL jalr_stats got %0d/%0d want %0d/%0d", brc, misc, b0, m0); end
        total++; if (pred_if !== 1'b0) begin bad++; $display("FAIL jalr_no_train got %b want 0", pred_if); end
        valid = 1'b0;
        #1;
        total++; if (pc_sel !== 1'b0) begin bad++; $display("FAIL jalr_invalid_sel got %b want 0", pc_sel); end
        set_mem(1, mk(3'd0, 7'h6F), 32'h300, 32'h5678, 0, 0, 1);
        #1;
        total++; if (pc_sel !== 1'b1 || redir !== 32'h5678) begin bad++; $display("FAIL jal_redir got %b/%h want 1/00005678", pc_sel, redir); end
        tick();
    endtask

    task automatic test_illegal();
        logic [31:0] b0;
        b0 = brc;
        set_mem(1, mk(3'd2, 7'h63), 32'h400, 32'h480, 0, 1, 0);
        #3;
        total++; if (ill !== 1'b1) begin bad++; $display("FAIL ill010_flag got %b want 1", ill); end
        total++; if (pc_sel !== 1'b0) begin bad++; $display("FAIL ill010_sel got %b want 0", pc_sel); end
        tick();
        inst = mk(3'd3, 7'h63);
        #1;
        total++; if (ill !== 1'b1) begin bad++; $display("FAIL ill011_flag got %b want 1", ill); end
        tick();
        total++; if (brc !== b0) begin bad++; $display("FAIL ill_no_count got %0d want %0d", brc, b0); end
        inst = mk(3'd4, 7'h63);
        #1;
        total++; if (ill !== 1'b0) begin bad++; $display("FAIL blt_not_ill got %b want 0", ill); end
        set_mem(1, mk(3'd0, 7'h63), 32'hFFFF_FFFC, 32'h800, 0, 0, 1);
        #1;
        total++; if (pc_sel !== 1'b1 || redir !== 32'h0) begin bad++; $display("FAIL pc_wrap got %b/%h want 1/00000000", pc_sel, redir); end
        tick();
    endtask

    task automatic test_collision();
        pc_if = 32'h14;
        set_mem(1, mk(3'd0, 7'h63), 32'h14, 32'h90, 0, 1, 0);
        #3;
        total++; if (pred_if !== 1'b0) begin bad++; $display("FAIL coll_old_value got %b want 0", pred_if); end
        tick();
        #1;
        total++; if (pred_if !== 1'b1) begin bad++; $display("FAIL coll_updated got %b want 1", pred_if); end
        set_mem(1, mk(3'd0, 7'h63), 32'h14, 32'h90, 0, 0, 1);
        #1;
        total++; if (pred_if !== 1'b1) begin bad++; $display("FAIL coll_old_value2 got %b want 1", pred_if); end
        tick();
        #1;
        total++; if (pred_if !== 1'b0) begin bad++; $display("FAIL coll_updated2 got %b want 0", pred_if); end
    endtask

    task automatic test_random();
        bit          s, il;
        logic [31:0] r;
        logic [6:0]  ops [4] = '{7'h63, 7'h63, 7'h6F, 7'h67};
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 59) == 0);
            pc_if = {$urandom_range(0, 3), 24'd0, 4'($urandom_range(0, 7)), 2'b00};
            set_mem($urandom_range(0, 9) != 0,
                    mk(3'($urandom), ($urandom_range(0, 7) == 0) ? 7'h13 : ops[$urandom_range(0, 3)]),
                    {$urandom_range(0, 3), 24'd0, 4'($urandom_range(0, 7)), 2'b00},
                    $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
            if (inst[14:12] == 3'd2 || inst[14:12] == 3'd3) pred = 1'b0;
            #3;
            exp_mem(s, r, il);
            if (pc_sel !== s || flush !== s || ill !== il || pred_if !== exp_pred(pc_if) || pred_if0 !== 1'b0) begin
                bad++;
                $display("FAIL rand_comb[%0d] got sel=%b fl=%b ill=%b pr=%b pr0=%b want sel=%b ill=%b pr=%b pr0=0",
                         n, pc_sel, flush, ill, pred_if, pred_if0, s, il, exp_pred(pc_if));
            end
            total++;
            if (s) begin
                total++; if (redir !== r) begin bad++; $display("FAIL rand_redir[%0d] got %h want %h", n, redir, r); end
            end
            tick();
            total++;
            if (brc !== 32'(m_br) || misc !== 32'(m_mis)) begin
                bad++;
                $display("FAIL rand_stats[%0d] got %0d/%0d want %0d/%0d", n, brc, misc, m_br, m_mis);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_mid_reset();
        pc_if = 32'h40;
        for (int i = 0; i < 3; i++) begin
            set_mem(1, mk(3'd0, 7'h63), 32'h40, 32'h80, 0, 1, 0);
            tick();
        end
        #1;
        total++; if (pred_if !== 1'b1) begin bad++; $display("FAIL mid_pre_pred got %b want 1", pred_if); end
        reset = 1'b1;
        #1;
        total++; if (pc_sel !== 1'b0 || pred_if !== 1'b0 || flush !== 1'b0) begin bad++; $display("FAIL mid_rst_outs got %b%b%b want 000", pc_sel, pred_if, flush); end
        tick();
        reset = 1'b0;
        valid = 1'b0;
        #3;
        total++; if (brc !== 32'd0 || misc !== 32'd0) begin bad++; $display("FAIL mid_rst_stats got %0d/%0d want 0/0", brc, misc); end
        total++; if (pred_if !== 1'b0) begin bad++; $display("FAIL mid_rst_history got %b want 0", pred_if); end
        tick();
    endtask

    initial begin
        test_reset();
        test_beq_train();
        test_bne();
        test_jump();
        test_illegal();
        test_collision();
        test_random();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
